rst_seq_multi: RTL



---
 rtl/rst_seq_multi.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/rst_seq_multi.sv
// rst_seq_multi: staggered multi-channel reset sequencer.
// Holds N_CH active-high resets asserted until the board reset is released
// and the PLL reports lock. Then it releases channel 0 first, and the other
// channels one after another, with STAGGER_CYC cycles between releases.
// A software request or a loss of lock re-runs the whole sequence.
// Optional feature macro: RST_SEQ_LOCK_DEBOUNCE_EN. When it is defined, the
// synchronised lock must stay high for LOCK_FILT consecutive cycles before
// the hold phase starts.

module rst_seq_multi #(
   parameter int N_CH        = 4,
   parameter int HOLD_CYC    = 16,
   parameter int STAGGER_CYC = 8,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 16,
   parameter int LOCK_FILT   = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            lock,
   input  logic            sw_rst_req,
   output logic [N_CH-1:0] rst_out,
   output logic            ready,
   output logic [2:0]      state_o
);

   localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

   typedef enum logic [2:0] {
      ST_ASSERT    = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_HOLD      = 3'd2,
      ST_RELEASE   = 3'd3,
      ST_RUN       = 3'd4
   } state_e;

   // Reject parameter sets the sequencer cannot honour.
   generate
      if (N_CH < 1 || N_CH > 16 || HOLD_CYC < 1 || STAGGER_CYC < 1 ||
          SYNC_STAGES < 2 || LOCK_FILT < 1 ||
          HOLD_CYC >= (1 << CNT_W) || STAGGER_CYC >= (1 << CNT_W)) begin : gBadParams
         $error("rst_seq_multi: illegal parameter combination");
      end
   endgenerate

   logic [SYNC_STAGES-1:0] rstSync_q;
   logic [SYNC_STAGES-1:0] lockSync_q;
   logic                   rstS;
   logic                   lockS;
   state_e                 state_q;
   logic [N_CH-1:0]        rstOut_q;
   logic                   ready_q;
   logic [CNT_W-1:0]       cnt_q;
   logic [IDX_W-1:0]       idx_q;
   logic                   lockAbort;
   logic                   abortReq;

`ifdef RST_SEQ_LOCK_DEBOUNCE_EN
   localparam int FILT_W = $clog2(LOCK_FILT + 1);
   logic [FILT_W-1:0]      filt_q;
`endif

   // Bring the reset release and the PLL lock level into the clk domain.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rstSync_q  <= '0;
         lockSync_q <= '0;
      end else begin
         rstSync_q  <= {rstSync_q[SYNC_STAGES-2:0], 1'b1};
         lockSync_q <= {lockSync_q[SYNC_STAGES-2:0], lock};
      end
   end

   assign rstS  = rstSync_q[SYNC_STAGES-1];
   assign lockS = lockSync_q[SYNC_STAGES-1];

   // Losing lock matters only after lock has been seen. While waiting for
   // lock, a low lock level is the normal condition and must not abort.
   assign lockAbort = !lockS &&
                      (state_q == ST_HOLD || state_q == ST_RELEASE || state_q == ST_RUN);
   assign abortReq  = (state_q != ST_ASSERT) && (sw_rst_req || lockAbort);

   // Sequencer: every output is registered, so releases are glitch-free and
   // aligned to clk. Only the board reset asserts the outputs asynchronously.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_ASSERT;
         rstOut_q <= '1;
         ready_q  <= 1'b0;
         cnt_q    <= '0;
         idx_q    <= '0;
`ifdef RST_SEQ_LOCK_DEBOUNCE_EN
         filt_q   <= '0;
`endif
      end else if (abortReq) begin
         state_q  <= ST_ASSERT;
         rstOut_q <= '1;
         ready_q  <= 1'b0;
         cnt_q    <= '0;
         idx_q    <= '0;
      end else begin
         case (state_q)
            ST_ASSERT: begin
               rstOut_q <= '1;
               ready_q  <= 1'b0;
               cnt_q    <= '0;
               idx_q    <= '0;
`ifdef RST_SEQ_LOCK_DEBOUNCE_EN
               filt_q   <= '0;
`endif
               if (rstS && !sw_rst_req) begin
                  state_q <= ST_WAIT_LOCK;
               end
            end
            ST_WAIT_LOCK: begin
               cnt_q <= '0;
`ifdef RST_SEQ_LOCK_DEBOUNCE_EN
               if (lockS) begin
                  if (filt_q == FILT_W'(LOCK_FILT - 1)) begin
                     filt_q  <= '0;
                     state_q <= ST_HOLD;
                  end else begin
                     filt_q <= filt_q + 1'b1;
                  end
               end else begin
                  filt_q <= '0;
               end
`else
               if (lockS) begin
                  state_q <= ST_HOLD;
               end
`endif
            end
            ST_HOLD: begin
               if (cnt_q == CNT_W'(HOLD_CYC - 1)) begin
                  rstOut_q[0] <= 1'b0;
                  cnt_q       <= '0;
                  idx_q       <= IDX_W'(1);
                  if (N_CH == 1) begin
                     state_q <= ST_RUN;
                     ready_q <= 1'b1;
                  end else begin
                     state_q <= ST_RELEASE;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_RELEASE: begin
               if (cnt_q == CNT_W'(STAGGER_CYC - 1)) begin
                  for (int i = 0; i < N_CH; i++) begin
                     if (IDX_W'(i) == idx_q) begin
                        rstOut_q[i] <= 1'b0;
                     end
                  end
                  cnt_q <= '0;
                  if (idx_q == IDX_W'(N_CH - 1)) begin
                     state_q <= ST_RUN;
                     ready_q <= 1'b1;
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_RUN: begin
               ready_q <= 1'b1;
            end
            default: begin
               state_q  <= ST_ASSERT;
               rstOut_q <= '1;
               ready_q  <= 1'b0;
               cnt_q    <= '0;
               idx_q    <= '0;
            end
         endcase
      end
   end

   assign rst_out = rstOut_q;
   assign ready   = ready_q;
   assign state_o = state_q;

endmodule
